// File: rtl/busoff_rec_pkg.sv
// Shared definitions for the bus-off recovery controller: FSM states and
// the recovery thresholds (11 recessive bits per sequence, 128 sequences).
package busoff_rec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } rec_state_t;

  localparam logic [3:0] REC_RUN_LEN    = 4'd11;
  localparam logic [7:0] REC_SEQ_TARGET = 8'd128;

endpackage

// File: rtl/rec_run_detect.sv
// Recessive-run detector: counts consecutive recessive samples and flags the
// sample that completes a run of REC_RUN_LEN bits. The completing sample
// wraps the count back to zero so bit_count never exceeds REC_RUN_LEN-1.
module rec_run_detect
  import busoff_rec_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       sample,
  input  logic       rxbit,
  output logic [3:0] bit_count,
  output logic       run_done
);

  assign run_done = enable && sample && rxbit &&
                    (bit_count == (REC_RUN_LEN - 4'd1));

  // Track the current recessive run; dominant samples restart it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bit_count <= '0;
    end else if (clear) begin
      bit_count <= '0;
    end else if (enable && sample) begin
      if (!rxbit || run_done) begin
        bit_count <= '0;
      end else begin
        bit_count <= bit_count + 4'd1;
      end
    end
  end

endmodule

// File: rtl/busoff_rec_ctrl.sv
// Bus-off recovery controller: after the node enters bus-off, counts 128
// sequences of 11 consecutive recessive bits and then signals rec_done.
// Optional macro BUSOFF_MANUAL_RESTART_EN: wait in HOLD for restart_req
// before counting starts. Without it, counting starts right after busoff rises.
module busoff_rec_ctrl
  import busoff_rec_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       busoff,
  input  logic       sample,
  input  logic       rxbit,
  input  logic       restart_req,
  output logic       rec_active,
  output logic       rec_done,
  output logic [7:0] seq_count,
  output logic [3:0] bit_count
);

  rec_state_t state;
  rec_state_t state_next;
  logic       run_done;
  logic       run_clear;
  logic       run_enable;
  logic       seq_last;

  // Counting only happens in COUNT; losing busoff aborts immediately.
  assign run_enable = (state == COUNT);
  assign run_clear  = (state != COUNT) || !busoff;
  assign seq_last   = run_done && (seq_count == (REC_SEQ_TARGET - 8'd1));

  assign rec_active = (state == COUNT);
  assign rec_done   = (state == DONE);

`ifndef BUSOFF_MANUAL_RESTART_EN
  logic unused_restart_req;
  assign unused_restart_req = restart_req;
`endif

  rec_run_detect u_run_detect (
    .clock     (clock),
    .reset     (reset),
    .clear     (run_clear),
    .enable    (run_enable),
    .sample    (sample),
    .rxbit     (rxbit),
    .bit_count (bit_count),
    .run_done  (run_done)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; busoff=0 always wins over sample progress.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (busoff) begin
`ifdef BUSOFF_MANUAL_RESTART_EN
          state_next = HOLD;
`else
          state_next = COUNT;
`endif
        end
      end
      HOLD: begin
`ifdef BUSOFF_MANUAL_RESTART_EN
        if (!busoff) begin
          state_next = IDLE;
        end else if (restart_req) begin
          state_next = COUNT;
        end
`else
        state_next = IDLE;
`endif
      end
      COUNT: begin
        if (!busoff) begin
          state_next = IDLE;
        end else if (seq_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!busoff) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Completed-sequence counter: zero outside COUNT/DONE, frozen in DONE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      seq_count <= '0;
    end else if (!busoff || state == IDLE || state == HOLD) begin
      seq_count <= '0;
    end else if (state == COUNT && run_done && seq_count != REC_SEQ_TARGET) begin
      seq_count <= seq_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_busoff_rec_ctrl.sv
// Self-checking bench for busoff_rec_ctrl: a vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_busoff_rec_ctrl;

  logic       clock;
  logic       reset;
  logic       busoff;
  logic       sample;
  logic       rxbit;
  logic       restart_req;
  logic       rec_active;
  logic       rec_done;
  logic [7:0] seq_count;
  logic [3:0] bit_count;

  int checks = 0;
  int errors = 0;

  localparam int M_IDLE  = 0;
  localparam int M_HOLD  = 1;
  localparam int M_COUNT = 2;
  localparam int M_DONE  = 3;

`ifdef BUSOFF_MANUAL_RESTART_EN
  localparam bit MANUAL = 1'b1;
`else
  localparam bit MANUAL = 1'b0;
`endif

  int m_mode = M_IDLE;
  int m_run  = 0;
  int m_seq  = 0;

  typedef struct {
    logic       rst;
    logic       bo;
    logic       smp;
    logic       rx;
    logic       rq;
    logic       ea;
    logic       ed;
    logic [7:0] es;
    logic [3:0] eb;
  } vec_t;

  vec_t vecs[12];

  busoff_rec_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .busoff      (busoff),
    .sample      (sample),
    .rxbit       (rxbit),
    .restart_req (restart_req),
    .rec_active  (rec_active),
    .rec_done    (rec_done),
    .seq_count   (seq_count),
    .bit_count   (bit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: recovery rules evaluated once per clock edge with plain counters.
  task automatic modelStep(input logic rst, input logic bo, input logic smp,
                           input logic rx, input logic rq);
    if (!rst) begin
      m_mode = M_IDLE; m_run = 0; m_seq = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_run = 0; m_seq = 0;
          if (bo) m_mode = MANUAL ? M_HOLD : M_COUNT;
        end
        M_HOLD: begin
          if (!bo) m_mode = M_IDLE;
          else if (rq) m_mode = M_COUNT;
        end
        M_COUNT: begin
          if (!bo) begin
            m_mode = M_IDLE; m_run = 0; m_seq = 0;
          end else if (smp) begin
            if (rx) begin
              m_run = m_run + 1;
              if (m_run == 11) begin
                m_run = 0;
                m_seq = m_seq + 1;
                if (m_seq == 128) m_mode = M_DONE;
              end
            end else begin
              m_run = 0;
            end
          end
        end
        default: begin
          if (!bo) begin
            m_mode = M_IDLE; m_run = 0; m_seq = 0;
          end
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic bo, input logic smp,
                               input logic rx, input logic rq);
    reset = rst; busoff = bo; sample = smp; rxbit = rx; restart_req = rq;
    modelStep(rst, bo, smp, rx, rq);
    @(posedge clock);
    #1;
  endtask

  task automatic checkExpect(input string name, input logic ea, input logic ed,
                             input logic [7:0] es, input logic [3:0] eb);
    checks++;
    if (rec_active !== ea || rec_done !== ed || seq_count !== es || bit_count !== eb) begin
      errors++;
      $display("[TB] FAIL %s: got active=%0b done=%0b seq=%0d bit=%0d, expected active=%0b done=%0b seq=%0d bit=%0d",
               name, rec_active, rec_done, seq_count, bit_count, ea, ed, es, eb);
    end
  endtask

  task automatic checkOutput(input string name);
    checkExpect(name, m_mode == M_COUNT, m_mode == M_DONE, 8'(m_seq), 4'(m_run));
  endtask

  task automatic sendSamples(input int n, input logic rx);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b1, rx, 1'b0);
  endtask

  task automatic enterCount(input string name);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    if (MANUAL) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkExpect(name, 1'b1, 1'b0, 8'd0, 4'd0);
  endtask

  initial begin
    reset = 1'b0; busoff = 1'b0; sample = 1'b0; rxbit = 1'b0; restart_req = 1'b0;

    // rst bo smp rx rq | active done seq bit   (default build: no HOLD)
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 4'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 4'd1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 4'd2};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'd2};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 4'd2};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 4'd2};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 4'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0};

    if (!MANUAL) begin
      for (int i = 0; i < 12; i++) begin
        applyStimulus(vecs[i].rst, vecs[i].bo, vecs[i].smp, vecs[i].rx, vecs[i].rq);
        checkExpect($sformatf("vec%0d", i), vecs[i].ea, vecs[i].ed, vecs[i].es, vecs[i].eb);
      end
    end

    // 10 recessive, 1 dominant, 11 recessive -> exactly one sequence.
    enterCount("run_enter");
    sendSamples(10, 1'b1);
    checkExpect("run_10rec", 1'b1, 1'b0, 8'd0, 4'd10);
    sendSamples(1, 1'b0);
    checkExpect("run_dom", 1'b1, 1'b0, 8'd0, 4'd0);
    sendSamples(11, 1'b1);
    checkExpect("run_11rec", 1'b1, 1'b0, 8'd1, 4'd0);

    // rxbit toggling without sample leaves the counters alone.
    sendSamples(3, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, i[0], 1'b0);
    checkExpect("nosample_hold", 1'b1, 1'b0, 8'd1, 4'd3);

    // Full recovery: rec_done exactly one cycle after sample #1408.
    enterCount("full_enter");
    sendSamples(1407, 1'b1);
    checkExpect("full_1407", 1'b1, 1'b0, 8'd127, 4'd10);
    sendSamples(1, 1'b1);
    checkExpect("full_1408", 1'b0, 1'b1, 8'd128, 4'd0);
    sendSamples(20, 1'b1);
    checkExpect("done_frozen", 1'b0, 1'b1, 8'd128, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkExpect("done_exit", 1'b0, 1'b0, 8'd0, 4'd0);

    // Abort on the completing sample: abort wins, nothing completes.
    enterCount("abort_enter");
    sendSamples(1407, 1'b1);
    checkExpect("abort_1407", 1'b1, 1'b0, 8'd127, 4'd10);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkExpect("abort_edge", 1'b0, 1'b0, 8'd0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkExpect("abort_after", 1'b0, 1'b0, 8'd0, 4'd0);

    // Reset mid-count at seq_count=50 overrides busoff and samples.
    enterCount("rst_enter");
    sendSamples(550, 1'b1);
    checkExpect("rst_seq50", 1'b1, 1'b0, 8'd50, 4'd0);
    sendSamples(4, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkExpect("rst_mid", 1'b0, 1'b0, 8'd0, 4'd0);

    // Manual restart: no counting in HOLD until restart_req is seen.
    if (MANUAL) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      sendSamples(200, 1'b1);
      checkExpect("hold_wait", 1'b0, 1'b0, 8'd0, 4'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      checkExpect("hold_restart", 1'b1, 1'b0, 8'd0, 4'd0);
      sendSamples(11, 1'b1);
      checkExpect("hold_count", 1'b1, 1'b0, 8'd1, 4'd0);
    end

    // Randomized traffic against the behavioural model.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rand_reset");
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 199) != 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 15) != 0,
                    $urandom_range(0, 7) == 0);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/busoff_rec_ctrl.md
BUSOFF_REC_CTRL -- requirements
Module: busoff_rec_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clock, reset.
REQ-002 Port clock SHALL be: clock  input  1  system clock; all state updates on the rising edge.
REQ-003 Port reset SHALL be: reset  input  1  synchronous active-low reset.
REQ-004 Port busoff SHALL be: busoff  input  1  level from the fault FSM; 1 = node in bus-off.
REQ-005 Port sample SHALL be: sample  input  1  one-cycle strobe at each bit sample point.
REQ-006 Port rxbit SHALL be: rxbit  input  1  sampled bus value, valid only with sample; 1 = recessive.
REQ-007 Port restart_req SHALL be: restart_req  input  1  host restart request (level or pulse).
REQ-008 Port rec_active SHALL be: rec_active  output  1  high in COUNT.
REQ-009 Port rec_done SHALL be: rec_done  output  1  recovery complete, to the fault FSM.
REQ-010 Port seq_count SHALL be: seq_count  output  8  completed 11-recessive-bit sequences, 0..128.
REQ-011 Port bit_count SHALL be: bit_count  output  4  current consecutive recessive bits, 0..10.

Function
REQ-012 The block SHALL have an FSM with states IDLE, HOLD, COUNT and DONE; all outputs SHALL be registered or Moore-decoded from state.
REQ-013 IDLE SHALL go to COUNT when busoff=1, or to HOLD when BUSOFF_MANUAL_RESTART_EN is defined; on entry to COUNT, bit_count and seq_count SHALL be cleared.
REQ-014 HOLD SHALL go to COUNT in the cycle after restart_req=1 is seen, and SHALL go to IDLE if busoff=0; busoff=0 SHALL take priority.
REQ-015 In COUNT, sample=1 with rxbit=0 SHALL clear bit_count.
REQ-016 In COUNT, sample=1 with rxbit=1 SHALL increment bit_count; the 11th consecutive recessive bit SHALL instead clear bit_count and increment seq_count in the same edge.
REQ-017 rxbit SHALL be ignored in any cycle with sample=0; counters SHALL hold.
REQ-018 COUNT SHALL go to DONE on the edge where seq_count becomes 128; rec_done SHALL be 1 in the first cycle after the sample that completes the 128th sequence (latency 1).
REQ-019 seq_count SHALL saturate at 128 and SHALL never wrap; bit_count SHALL never exceed 10.
REQ-020 DONE SHALL hold rec_done=1 and freeze the counters until busoff=0, then go to IDLE with rec_done=0 the next cycle.
REQ-021 In COUNT, busoff=0 SHALL abort to IDLE and SHALL clear both counters, even if the same cycle carries the completing sample; abort SHALL win.
REQ-022 In IDLE, bit_count, seq_count and rec_done SHALL be 0.

Reset
REQ-023 reset=0 at any clock edge SHALL force IDLE, rec_active=0, rec_done=0, seq_count=0 and bit_count=0, including mid-count; reset SHALL override all inputs.

Configuration
REQ-024 Macro BUSOFF_MANUAL_RESTART_EN defined: bus-off entry SHALL wait in HOLD for restart_req before counting.
REQ-025 Macro BUSOFF_MANUAL_RESTART_EN undefined: HOLD SHALL be unreachable, restart_req SHALL be ignored, and counting SHALL start the cycle after busoff rises.

Structure
REQ-026 Shared package busoff_rec_pkg SHALL hold the state enum typedef and the constants REC_RUN_LEN=11 and REC_SEQ_TARGET=128.
REQ-027 Recessive-run detection (bit_count plus run-complete pulse) SHALL be a sub-module rec_run_detect; the FSM and seq_count SHALL stay in busoff_rec_ctrl.

Verification
REQ-028 The bench SHALL drive busoff=1, then 128x11 recessive samples -> rec_done=1 one cycle after sample #1408, and seq_count=128.
REQ-029 The bench SHALL drive 10 recessive, 1 dominant, 11 recessive samples -> seq_count=1 and bit_count=0.
REQ-030 The bench SHALL drop busoff=0 on the same cycle as the completing sample (seq 127->128) -> IDLE, rec_done stays 0, counters 0.
REQ-031 The bench SHALL pulse reset=0 at seq_count=50 -> next cycle IDLE, all outputs 0.
REQ-032 With BUSOFF_MANUAL_RESTART_EN, the bench SHALL drive busoff=1 plus 200 recessive samples without restart_req -> seq_count stays 0; then restart_req -> counting starts.
REQ-033 The bench SHALL drive rxbit toggling while sample=0 -> bit_count unchanged.
